// File: rtl/bus_serial_port.sv
// Memory-mapped serial transmitter: bus writes fill a small word FIFO, an FSM
// frames each 32-bit word (start, 32 data bits LSB first, stop) onto tx.
module bus_serial_port #(
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic        data_bus_read,
  output logic        tx,
  output logic        irq_empty
);

  // state | meaning
  // IDLE  | line high, waiting for a queued word
  // START | start bit (tx low) for CLK_DIV cycles
  // DATA  | 32 data bits, LSB first, CLK_DIV cycles each
  // STOP  | stop bit (tx high); pops the next word directly if one is queued
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            state, state_next;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic [BW-1:0]     baud;
  logic [4:0]        bit_cnt;
  logic [31:0]       shift;
  logic              ovf;
  logic              pop, push_req, push_ok, drop, clr_ovf;
  logic              baud_done, full, empty, busy;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};
  assign baud_done   = (baud == BW'(CLK_DIV - 1));
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign busy        = (state != IDLE) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (!empty) begin pop = 1'b1; state_next = START; end
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_cnt == 5'd31) state_next = STOP;
      STOP:  if (baud_done) begin
               if (!empty) begin pop = 1'b1; state_next = START; end
               else state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_bus_read = 1'b0;
    if (cs && !wr_rd) begin
      case (addr[3:2])
        2'd0: data_bus_read = full;
        2'd1: data_bus_read = busy;
        2'd2: data_bus_read = ovf;
        2'd3: data_bus_read = empty;
        default: data_bus_read = 1'b0;
      endcase
    end
  end

  // A push into a full FIFO still lands if the FSM frees a slot on the same edge.
  always_comb begin
    push_req   = cs && wr_rd && (addr[3:2] == 2'd0);
    clr_ovf    = cs && wr_rd && (addr[3:2] == 2'd3);
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_bus_write;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx        <= 1'b1;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      baud      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      ovf       <= 1'b0;
      irq_empty <= 1'b1;
    end else begin
      count     <= count_next;
      irq_empty <= (count_next == '0) && (state_next == IDLE);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        shift  <= mem[rd_ptr];
      end
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      case (state)
        IDLE: if (pop) begin tx <= 1'b0; baud <= '0; end
        START:
          if (baud_done) begin
            baud    <= '0;
            tx      <= shift[0];
            bit_cnt <= '0;
          end else baud <= baud + BW'(1);
        DATA:
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) tx <= 1'b1;
            else begin
              tx    <= shift[1];
              shift <= shift >> 1;
            end
          end else baud <= baud + BW'(1);
        STOP:
          if (baud_done) begin
            baud <= '0;
            if (pop) tx <= 1'b0;
          end else baud <= baud + BW'(1);
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_serial_port.sv
// Bench for bus_serial_port: reset/status vector table, directed frame
// sequences and random bus traffic against a queue-based frame model.
module tb_bus_serial_port;
  localparam int DEPTH = 4;
  localparam int CD    = 4;
  localparam int FRAME = 34 * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_bus_write;
  logic        cs, wr_rd;
  logic        data_bus_read, tx, irq_empty;

  always #5 clk = ~clk;

  bus_serial_port #(.DEPTH(DEPTH), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .cs(cs), .wr_rd(wr_rd),
    .data_bus_write(data_bus_write), .data_bus_read(data_bus_read),
    .tx(tx), .irq_empty(irq_empty)
  );

  int checks = 0;
  int errors = 0;

  // Model: queued words, the frame on the wire and its elapsed cycle count.
  logic [31:0] q[$];
  bit          m_active;
  logic [31:0] m_word;
  int          m_t;
  bit          m_ovf;

  typedef struct {
    logic [31:0] a;
    logic        c;
    logic        w;
    logic        exp;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_t      = 0;
    m_ovf    = 0;
  endtask

  function automatic logic m_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / CD;
    if (idx == 0) return 1'b0;
    if (idx <= 32) return m_word[idx-1];
    return 1'b1;
  endfunction

  function automatic logic m_status(input logic [1:0] a);
    case (a)
      2'd0: return q.size() == DEPTH;
      2'd1: return m_active || q.size() != 0;
      2'd2: return m_ovf;
      default: return q.size() == 0;
    endcase
  endfunction

  task automatic model_edge();
    bit popped, push, clr;
    if (rst) begin model_reset(); return; end
    push   = cs && wr_rd && addr[3:2] == 2'd0;
    clr    = cs && wr_rd && addr[3:2] == 2'd3;
    popped = 0;
    if (m_active) begin
      m_t++;
      if (m_t == FRAME) m_active = 0;
    end
    if (!m_active && q.size() != 0) begin
      m_word   = q.pop_front();
      m_active = 1;
      m_t      = 0;
      popped   = 1;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(data_bus_write);
      else m_ovf = 1;
    end
    if (clr && !(push && q.size() == DEPTH && !popped && m_ovf)) m_ovf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", tx, m_tx());
    check("irq_empty", irq_empty, q.size() == 0 && !m_active);
  endtask

  task automatic idle_bus();
    cs = 0; wr_rd = 0; addr = 0; data_bus_write = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cs = 1; wr_rd = 1; addr = a; data_bus_write = d;
    step();
    idle_bus();
  endtask

  task automatic read_chk(input string name, input logic [31:0] a);
    cs = 1; wr_rd = 0; addr = a;
    #1;
    check(name, data_bus_read, m_status(a[3:2]));
    idle_bus();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_active || q.size() != 0) && n < limit) begin step(); n++; end
    if (n == limit) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", limit);
    end
    repeat (2) step();
  endtask

  initial begin
    vec_t vt[8];
    int   n;
    logic [31:0] w;
    logic bsy;

    // Expected status after reset: full 0, busy 0, overflow 0, empty 1.
    vt[0] = '{32'h0000_000C, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h0000_0004, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[3] = '{32'h0000_0008, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h0000_000C, 1'b0, 1'b0, 1'b0};
    vt[5] = '{32'h0000_000C, 1'b1, 1'b1, 1'b0};
    vt[6] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1};
    vt[7] = '{32'h0000_0004, 1'b0, 1'b1, 1'b0};

    rst = 1; idle_bus(); model_reset();
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq_empty, 1'b1);
    for (int i = 0; i < 8; i++) begin
      addr = vt[i].a; cs = vt[i].c; wr_rd = vt[i].w;
      #1;
      check($sformatf("vec%0d", i), data_bus_read, vt[i].exp);
    end
    idle_bus();
    repeat (2) step();
    rst = 0;
    repeat (2) step();
    read_chk("idle_empty", 32'hC);
    step();
    read_chk("idle_busy", 32'h4);

    // Single frame: tx high for the push cycle, then 4 low cycles of start bit.
    bus_write(32'h0, 32'hA5A5_0001);
    check("latency_tx_high", tx, 1'b1);
    n = 0;
    for (int i = 0; i < CD; i++) begin step(); if (tx === 1'b0) n++; end
    checks++;
    if (n != CD) begin
      errors++;
      $display("FAIL start_bit_len: got %0d low cycles expected %0d", n, CD);
    end
    step();
    check("first_data_bit", tx, 1'b1);
    drain(2 * FRAME);
    check("single_irq_back", irq_empty, 1'b1);

    // Back-to-back frames with busy read every cycle.
    bus_write(32'h0, 32'h0000_0000);
    bus_write(32'h0, 32'hFFFF_FFFF);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      bsy = m_status(2'd1);
      read_chk("b2b_busy", 32'h4);
      step();
      if (i < 2 * FRAME - 2) check("b2b_busy_model", bsy, 1'b1);
    end
    drain(2 * FRAME);

    // Overflow: one frame in flight, then five pushes.
    bus_write(32'h0, 32'h1111_0000);
    repeat (3) step();
    for (int i = 1; i <= 5; i++) begin
      bus_write(32'h0, 32'h2222_0000 + i);
      read_chk("ovf_full", 32'h0);
      read_chk("ovf_flag", 32'h8);
    end
    check("ovf_set_model", m_ovf, 1'b1);
    bus_write(32'hC, 32'h0);
    read_chk("ovf_cleared", 32'h8);

    // Push exactly on the STOP->START pop edge while full.
    n = 0;
    while (!(m_active && m_t == FRAME - 1) && n < 2 * FRAME) begin step(); n++; end
    if (n == 2 * FRAME) begin
      errors++;
      $display("FAIL stop_edge_timeout: never reached end of frame");
    end
    bus_write(32'h0, 32'h3333_CAFE);
    read_chk("simul_full", 32'h0);
    read_chk("simul_ovf", 32'h8);
    check("simul_count_model", q.size() == DEPTH, 1'b1);
    drain(6 * FRAME);

    // Reset mid-frame at data bit 10 with overflow set.
    for (int i = 0; i < 6; i++) bus_write(32'h0, 32'h4444_0000 + i);
    n = 0;
    while (!(m_active && m_t == 11 * CD + 1) && n < 2 * FRAME) begin step(); n++; end
    if (n == 2 * FRAME) begin
      errors++;
      $display("FAIL bit10_timeout: never reached data bit 10");
    end
    read_chk("pre_rst_ovf", 32'h8);
    #1 rst = 1;
    #1;
    model_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq_empty, 1'b1);
    read_chk("rst_empty", 32'hC);
    read_chk("rst_ovf", 32'h8);
    step();
    rst = 0;
    step();
    bus_write(32'h0, 32'h1234_5678);
    drain(2 * FRAME);

    // Random bus traffic.
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 99);
      w = $urandom;
      if (n < 3) begin
        cs = 1; wr_rd = 1; addr = 32'h0; data_bus_write = w;
      end else if (n < 5) begin
        cs = 1; wr_rd = 1; addr = 32'hC; data_bus_write = w;
      end else if (n < 8) begin
        cs = 1; wr_rd = 1; addr = (n < 6) ? 32'h4 : 32'h8; data_bus_write = w;
      end else if (n < 40) begin
        read_chk("rand_read", {w[31:4], 2'($urandom_range(0, 3)), w[1:0]});
      end else if (n < 45) begin
        cs = 0; wr_rd = 0; addr = 32'h0;
        #1;
        check("rand_cs0", data_bus_read, 1'b0);
      end
      step();
      idle_bus();
    end
    drain(6 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
